// File: rtl/fpga_clk_ctrl.sv
// CPU clock generator for the FPGA top level: run-time divide ratio plus run/halt/step/breakpoint
// control and a saturating count of CPU clock rising edges.
module fpga_clk_ctrl #(
    parameter int unsigned          CNT_WIDTH   = 32,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_DIV = CNT_WIDTH'(100000000),
    parameter int unsigned          PC_WIDTH    = 32,
    parameter int unsigned          CYC_WIDTH   = 32
) (
    input  logic                 CLK_GEN,
    input  logic                 RST,
    input  logic [1:0]           MODE,
    input  logic                 DIV_LOAD,
    input  logic [CNT_WIDTH-1:0] DIV_VALUE,
    input  logic                 STEP_REQ,
    input  logic [PC_WIDTH-1:0]  BP_PC,
    input  logic [PC_WIDTH-1:0]  PC_IN,
    output logic                 CLK,
    output logic                 CLK_EN,
    output logic                 RUNNING,
    output logic                 BP_HIT,
    output logic [CYC_WIDTH-1:0] CYCLE_COUNT
);

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StHalt  = 2'b01,
        StStep  = 2'b10,
        StBreak = 2'b11
    } state_t;

    state_t               r_state, w_state_next, w_mode_state;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_next;
    logic [CNT_WIDTH-1:0] r_div, w_div_next;
    logic [CYC_WIDTH-1:0] r_cyc, w_cyc_next;
    logic                 r_clk, w_clk_next;
    logic                 r_clk_en;
    logic                 r_pend, w_pend_next;
    logic                 r_sreq;
    logic                 r_bp, w_bp_next;
    logic                 r_running, w_running_next;
    logic                 w_rise, w_fall, w_sreq_edge, w_bp_match;

    // Divider. r_running is the permission term for the state currently registered, so a MODE
    // change landing on a terminal count is only seen from the next cycle on.
    always_comb begin
        w_cnt_next = r_cnt + CNT_WIDTH'(1);
        w_clk_next = r_clk;
        w_rise     = 1'b0;
        w_fall     = 1'b0;
        if ((r_cnt > r_div) || (!r_clk && !r_running)) begin
            // Shrunk divide ratio or a blocked low phase: restart a full half period.
            w_cnt_next = '0;
        end else if (r_cnt == r_div) begin
            w_cnt_next = '0;
            w_clk_next = ~r_clk;
            w_rise     = ~r_clk;
            w_fall     = r_clk;
        end
    end

    always_comb begin
        w_div_next = r_div;
        if (DIV_LOAD) begin
            w_div_next = (DIV_VALUE == '0) ? CNT_WIDTH'(1) : DIV_VALUE;
        end
    end

    assign w_cyc_next = (w_rise && !(&r_cyc)) ? r_cyc + CYC_WIDTH'(1) : r_cyc;

    assign w_sreq_edge = STEP_REQ & ~r_sreq;
    assign w_bp_match  = w_fall && (PC_IN == BP_PC);

    always_comb begin
        case (MODE)
            2'b00:   w_mode_state = StRun;
            2'b01:   w_mode_state = StHalt;
            2'b10:   w_mode_state = StStep;
            default: w_mode_state = StRun;
        endcase
    end

    always_comb begin
        w_state_next = w_mode_state;
        w_bp_next    = 1'b0;
        if (r_state == StBreak) begin
            if (MODE == 2'b11) begin
                if (!w_sreq_edge) begin
                    w_state_next = StBreak;
                    w_bp_next    = 1'b1;
                end
            end
        end else if ((MODE == 2'b11) && w_bp_match) begin
            w_state_next = StBreak;
            w_bp_next    = 1'b1;
        end
    end

    always_comb begin
        w_pend_next = 1'b0;
        if ((r_state == StStep) && (w_state_next == StStep)) begin
            w_pend_next = w_rise ? 1'b0 : (r_pend | w_sreq_edge);
        end
    end

    assign w_running_next = (w_state_next == StRun) || ((w_state_next == StStep) && w_pend_next);

    always_ff @(posedge CLK_GEN or posedge RST) begin
        if (RST) begin
            r_state   <= StRun;
            r_cnt     <= '0;
            r_div     <= DEFAULT_DIV;
            r_cyc     <= '0;
            r_clk     <= 1'b0;
            r_clk_en  <= 1'b0;
            r_pend    <= 1'b0;
            r_sreq    <= 1'b0;
            r_bp      <= 1'b0;
            r_running <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_div     <= w_div_next;
            r_cyc     <= w_cyc_next;
            r_clk     <= w_clk_next;
            r_clk_en  <= w_rise;
            r_pend    <= w_pend_next;
            r_sreq    <= STEP_REQ;
            r_bp      <= w_bp_next;
            r_running <= w_running_next;
        end
    end

    assign CLK         = r_clk;
    assign CLK_EN      = r_clk_en;
    assign RUNNING     = r_running;
    assign BP_HIT      = r_bp;
    assign CYCLE_COUNT = r_cyc;

endmodule

// File: tb/tb_fpga_clk_ctrl.sv
// Bench for fpga_clk_ctrl: directed bring-up scenarios followed by random mode/step/divide
// traffic, every cycle compared against a behavioural model of the clock controller.
module tb_fpga_clk_ctrl;

    localparam int unsigned CW   = 32;
    localparam int unsigned PW   = 8;
    localparam int unsigned YW   = 4;
    localparam int          DDIV = 3;
    localparam int          CMAX = 15;

    logic          CLK_GEN = 1'b0;
    logic          RST = 1'b0;
    logic [1:0]    MODE = 2'b00;
    logic          DIV_LOAD = 1'b0;
    logic [CW-1:0] DIV_VALUE = '0;
    logic          STEP_REQ = 1'b0;
    logic [PW-1:0] BP_PC = 8'h10;
    logic [PW-1:0] PC_IN = '0;
    logic          CLK, CLK_EN, RUNNING, BP_HIT;
    logic [YW-1:0] CYCLE_COUNT;

    fpga_clk_ctrl #(
        .CNT_WIDTH   (CW),
        .DEFAULT_DIV (32'(DDIV)),
        .PC_WIDTH    (PW),
        .CYC_WIDTH   (YW)
    ) dut (
        .CLK_GEN     (CLK_GEN),
        .RST         (RST),
        .MODE        (MODE),
        .DIV_LOAD    (DIV_LOAD),
        .DIV_VALUE   (DIV_VALUE),
        .STEP_REQ    (STEP_REQ),
        .BP_PC       (BP_PC),
        .PC_IN       (PC_IN),
        .CLK         (CLK),
        .CLK_EN      (CLK_EN),
        .RUNNING     (RUNNING),
        .BP_HIT      (BP_HIT),
        .CYCLE_COUNT (CYCLE_COUNT)
    );

    always #5 CLK_GEN = ~CLK_GEN;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the controller's visible state is "last MODE seen" plus a stopped-on-breakpoint flag.
    int       m_cnt, m_div, m_cyc;
    bit       m_clk, m_en, m_pend, m_sreq_q, m_bp;
    bit [1:0] m_mode_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_permit();
        if (m_bp) return 1'b0;
        return (m_mode_q == 2'd0) || (m_mode_q == 2'd3) || ((m_mode_q == 2'd2) && m_pend);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_div = DDIV; m_cyc = 0; m_clk = 0; m_en = 0;
        m_pend = 0; m_sreq_q = 0; m_bp = 0; m_mode_q = 2'd0;
    endtask

    task automatic tick();
        int       n_cnt, n_div, n_cyc;
        bit       n_clk, n_pend, n_bp, rise, fall, sedge;
        if (RST) begin
            n_cnt = 0; n_div = DDIV; n_cyc = 0; n_clk = 0; n_pend = 0; n_bp = 0; rise = 0;
            sedge = 0;
        end else begin
            rise = 0; fall = 0; n_clk = m_clk; n_cnt = m_cnt + 1;
            if (m_cnt > m_div || (!m_clk && !m_permit())) begin
                n_cnt = 0;
            end else if (m_cnt == m_div) begin
                n_cnt = 0; n_clk = !m_clk; rise = !m_clk; fall = m_clk;
            end
            sedge = STEP_REQ && !m_sreq_q;
            if (m_bp) n_bp = (MODE == 2'd3) && !sedge;
            else      n_bp = (MODE == 2'd3) && fall && (PC_IN == BP_PC);
            if (m_mode_q == 2'd2 && MODE == 2'd2) n_pend = rise ? 1'b0 : (m_pend || sedge);
            else                                  n_pend = 1'b0;
            n_cyc = (rise && m_cyc != CMAX) ? m_cyc + 1 : m_cyc;
            n_div = DIV_LOAD ? ((DIV_VALUE == 0) ? 1 : int'(DIV_VALUE)) : m_div;
        end
        @(posedge CLK_GEN);
        #1;
        m_cnt = n_cnt; m_div = n_div; m_cyc = n_cyc; m_clk = n_clk; m_en = rise;
        m_pend = n_pend; m_bp = n_bp;
        m_sreq_q = RST ? 1'b0 : STEP_REQ;
        m_mode_q = RST ? 2'd0 : MODE;
        check_eq("clk", 32'(CLK), 32'(m_clk));
        check_eq("clk_en", 32'(CLK_EN), 32'(m_en));
        check_eq("running", 32'(RUNNING), 32'(m_permit()));
        check_eq("bp_hit", 32'(BP_HIT), 32'(m_bp));
        check_eq("cycle_count", 32'(CYCLE_COUNT), 32'(m_cyc));
    endtask

    task automatic apply_reset(input int hold);
        RST = 1'b1;
        #1;
        model_reset();
        check_eq("rst_clk", 32'(CLK), 32'd0);
        check_eq("rst_cyc", 32'(CYCLE_COUNT), 32'd0);
        check_eq("rst_bp", 32'(BP_HIT), 32'd0);
        repeat (hold) tick();
        RST = 1'b0;
    endtask

    // Ticks until CLK is high, returning how many it took (bounded).
    task automatic ticks_to_high(output int n);
        n = 0;
        do begin tick(); n++; end while (!CLK && n < 60);
    endtask

    task automatic measure_period(output int n);
        int w = 0;
        while (!CLK_EN && w < 40) begin tick(); w++; end
        n = 0;
        do begin tick(); n++; end while (!CLK_EN && n < 40);
    endtask

    initial begin
        int n, c_h;
        model_reset();
        #2;
        // Free-running default divide.
        apply_reset(3);
        ticks_to_high(n);
        check_eq("first_rise", 32'(n), 32'd4);
        repeat (32 - n) tick();
        check_eq("cyc_after_32", 32'(CYCLE_COUNT), 32'd4);

        // Halt during a high phase.
        n = 0;
        while (!m_clk && n < 20) begin tick(); n++; end
        MODE = 2'd1;
        c_h = m_cyc;
        repeat (40) tick();
        check_eq("halt_frozen", 32'(CYCLE_COUNT), 32'(c_h));
        check_eq("halt_clk_low", 32'(CLK), 32'd0);
        MODE = 2'd0;
        n = 0;
        do begin tick(); n++; end while (!RUNNING && n < 10);
        n = 0;
        do begin tick(); n++; end while (!CLK_EN && n < 40);
        check_eq("resume_rise", 32'(n), 32'd4);

        // Single step: three accepted requests, one ignored while a step is pending.
        MODE = 2'd2;
        apply_reset(2);
        repeat (20) tick();
        for (int i = 0; i < 3; i++) begin
            STEP_REQ = 1'b1; tick(); tick(); STEP_REQ = 1'b0;
            if (i == 2) begin tick(); STEP_REQ = 1'b1; tick(); STEP_REQ = 1'b0; end
            repeat (18) tick();
        end
        check_eq("step_rises", 32'(CYCLE_COUNT), 32'd3);

        // Breakpoint at 0x10 with PC advancing by 4 per pulse, then a self-loop at 0x10.
        MODE = 2'd3;
        BP_PC = 8'h10;
        PC_IN = 8'h00;
        apply_reset(2);
        n = 0;
        while (!BP_HIT && n < 200) begin
            tick(); n++;
            if (!m_bp) PC_IN = (m_cyc == 0) ? 8'h00 : 8'(4 * (m_cyc - 1));
        end
        check_eq("bp_hit_seen", 32'(BP_HIT), 32'd1);
        check_eq("bp_at_pulse", 32'(CYCLE_COUNT), 32'd5);
        check_eq("bp_pc", 32'(PC_IN), 32'h10);
        repeat (40) tick();
        check_eq("bp_hold_cyc", 32'(CYCLE_COUNT), 32'd5);
        STEP_REQ = 1'b1; tick(); STEP_REQ = 1'b0;
        check_eq("bp_resume", 32'(BP_HIT), 32'd0);
        repeat (30) tick();
        check_eq("bp_reloop_cyc", 32'(CYCLE_COUNT), 32'd6);
        check_eq("bp_reloop_hit", 32'(BP_HIT), 32'd1);
        MODE = 2'd0;
        tick();
        check_eq("bp_mode_exit", 32'(BP_HIT), 32'd0);

        // Divide-ratio reload below the running count, then a zero reload.
        apply_reset(1);
        n = 0;
        while (m_cnt != 2 && n < 20) begin tick(); n++; end
        DIV_VALUE = 1; DIV_LOAD = 1'b1; tick(); DIV_LOAD = 1'b0;
        tick();
        check_eq("wrap_no_toggle", 32'(CLK), 32'd0);
        measure_period(n);
        check_eq("div1_period", 32'(n), 32'd4);
        DIV_VALUE = 0; DIV_LOAD = 1'b1; tick(); DIV_LOAD = 1'b0;
        measure_period(n);
        check_eq("div0_period", 32'(n), 32'd4);

        // Reset mid high phase restores the default divide.
        DIV_VALUE = 7; DIV_LOAD = 1'b1; tick(); DIV_LOAD = 1'b0;
        apply_reset(1);
        DIV_VALUE = 7; DIV_LOAD = 1'b1; tick(); DIV_LOAD = 1'b0;
        n = 0;
        while (!(m_cyc == 5 && m_clk) && n < 300) begin tick(); n++; end
        check_eq("pre_rst_clk", 32'(CLK), 32'd1);
        apply_reset(2);
        ticks_to_high(n);
        check_eq("rst_div_default", 32'(n), 32'd4);

        repeat (160) tick();
        check_eq("cyc_saturate", 32'(CYCLE_COUNT), 32'(CMAX));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) apply_reset(1);
            if ($urandom_range(0, 59) == 0) MODE = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) STEP_REQ = ~STEP_REQ;
            DIV_LOAD = ($urandom_range(0, 79) == 0);
            DIV_VALUE = 32'($urandom_range(0, 4));
            if (m_en) PC_IN = 8'($urandom_range(0, 7) * 4);
            tick();
        end
        DIV_LOAD = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_clk_ctrl.md
Name: fpga_clk_ctrl

Overview:
- Parametrised successor to the fixed free-running CPU clock divider in the FPGA top level.
- Derives the CPU clock CLK from the board clock CLK_GEN using a divide ratio that can be changed at run time.
- Adds run, halt, single-step and PC-breakpoint modes, plus a cycle counter, for bring-up on the board.
- Sits between the board clock and the cpu/imem/dmem instances. PC_IN is taken from the CPU's IF-stage PC.

Parameters:
- CNT_WIDTH, 32, width of the half-period counter and of DIV_VALUE.
- DEFAULT_DIV, 100000000, half-period terminal count loaded at reset. Half period = DEFAULT_DIV+1 CLK_GEN cycles.
- PC_WIDTH, 32, width of PC_IN and BP_PC.
- CYC_WIDTH, 32, width of CYCLE_COUNT.

Ports:
- CLK_GEN  input  1  board clock; the only clock in the block.
- RST  input  1  asynchronous, active-high reset.
- MODE  input  2  00 RUN, 01 HALT, 10 STEP, 11 BREAK-RUN.
- DIV_LOAD  input  1  one-cycle strobe: load DIV_VALUE as the new terminal count.
- DIV_VALUE  input  CNT_WIDTH  new terminal count; value 0 is treated as 1.
- STEP_REQ  input  1  step/resume request, synchronous to CLK_GEN; acted on at its rising edge.
- BP_PC  input  PC_WIDTH  breakpoint address.
- PC_IN  input  PC_WIDTH  current CPU PC.
- CLK  output  1  divided CPU clock, registered.
- CLK_EN  output  1  one-CLK_GEN-cycle pulse in the same cycle CLK goes 0->1.
- RUNNING  output  1  1 when the next rising edge of CLK is permitted.
- BP_HIT  output  1  1 while stopped on a breakpoint.
- CYCLE_COUNT  output  CYC_WIDTH  number of CLK rising edges issued; saturates at all-ones.

Behaviour:

Reset (RST=1, asynchronous, active-high):
- CLK=0, CLK_EN=0, BP_HIT=0, CYCLE_COUNT=0.
- Counter cnt=0, div_r=DEFAULT_DIV, step_pending=0, STEP_REQ edge-detect register=0, FSM in RUN.
- RST asserted mid-pulse forces CLK low immediately.

Divider:
- cnt increments each CLK_GEN cycle up to div_r.
- When cnt==div_r, a toggle decision is made and cnt returns to 0.
- If CLK=1: always toggle to 0, so a started high phase always completes.
- If CLK=0: toggle to 1 only if permitted (see FSM). If not permitted, CLK stays 0 and cnt is held at 0 until permitted. After release there is a full half period before the rising edge.
- DIV_LOAD: div_r <= max(DIV_VALUE,1) in the next cycle. If cnt > new div_r, cnt wraps to 0 with no toggle.

Rising-edge bookkeeping (every permitted 0->1 toggle):
- CLK_EN=1 for exactly that CLK_GEN cycle.
- CYCLE_COUNT increments, saturating at all-ones.

FSM states: RUN, HALT, STEP, BREAK.
- Evaluated every CLK_GEN cycle.
- MODE 00 -> RUN, 01 -> HALT, 10 -> STEP, 11 -> RUN with breakpoint armed.
- BREAK is entered only via a breakpoint hit.
- While in BREAK, a MODE change away from 11 exits to the state that MODE selects and clears BP_HIT.

Permission to rise:
- RUN: always.
- HALT: never.
- STEP: only when step_pending=1.
- BREAK: never.

Step:
- In STEP, a STEP_REQ rising edge sets step_pending. Edges arriving while step_pending=1 are ignored.
- step_pending clears in the cycle the rising edge is issued, so each request produces exactly one CPU clock pulse.
- Leaving STEP clears step_pending.

Breakpoint (MODE 11):
- On each falling toggle, compare PC_IN with BP_PC. PC is stable mid-cycle.
- On a match: next state BREAK, BP_HIT=1. Further rising edges are blocked; CLK rests at 0.
- A STEP_REQ rising edge in BREAK clears BP_HIT and resumes run with the breakpoint re-armed.
- A self-loop at BP_PC therefore hits again after one pulse, which is the required behaviour.

RUNNING:
- Equals the permission-to-rise term, registered alongside the state.

Simultaneous events:
- DIV_LOAD with a terminal count in the same cycle: the toggle uses the old div_r.
- A MODE change and a terminal count in the same cycle: the permission check uses the state registered before the change.
- A breakpoint match and MODE leaving 11 in the same cycle: MODE wins and BP_HIT stays 0.

Test Plan:
- DEFAULT_DIV=3, MODE=00, release reset -> CLK period 8 CLK_GEN cycles, first rise at cycle 4; CLK_EN pulses every 8 cycles; CYCLE_COUNT=4 after 32 cycles.
- MODE=01 asserted while CLK high -> current high phase completes, CLK then stays 0, RUNNING=0, CYCLE_COUNT frozen; back to 00 -> first rise 4 cycles later.
- MODE=10, three STEP_REQ pulses spaced 20 cycles apart, plus a fourth pulse while step_pending=1 -> exactly 3 CLK rises, CYCLE_COUNT +3.
- MODE=11, BP_PC=0x10, PC_IN steps 0x0,0x4,...,0x10 -> BP_HIT=1 at the falling toggle with PC_IN=0x10, no further rises; STEP_REQ -> BP_HIT=0, run resumes.
- DIV_LOAD with DIV_VALUE=1 while cnt=2 and div_r=3 -> cnt wraps with no toggle, then period 4; DIV_VALUE=0 -> behaves as 1.
- RST pulsed mid high phase with CYCLE_COUNT=5 -> CLK=0, CYCLE_COUNT=0, div_r=DEFAULT_DIV immediately; CYC_WIDTH=4 run past 15 rises -> CYCLE_COUNT holds at 15.
